// File: rtl/bcd_display_scan_if.sv
// rtl/bcd_display_scan_if.sv - BCD digit in / 7-segment scan out bundle for bcd_display_scan
// master drives the digits and strobes; slave is the display scanner.
interface bcd_display_scan_if;
   logic       load;
   logic [3:0] d3;
   logic [3:0] d2;
   logic [3:0] d1;
   logic [3:0] d0;
   logic       colon;
   logic       blank;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       scan_wrap;

   modport master (
      output load, d3, d2, d1, d0, colon, blank,
      input  seg, dp, an, scan_wrap
   );

   modport slave (
      input  load, d3, d2, d1, d0, colon, blank,
      output seg, dp, an, scan_wrap
   );
endinterface

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - latches four BCD digits and scans them onto a common-anode 7-segment bus
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3 and 2.
module bcd_display_scan #(
   parameter int SCAN_DIV = 4,
   parameter int DIV_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   bcd_display_scan_if.slave  bus
);

   logic [3:0]       digit_q [4];
   logic [3:0]       digit_d [4];
   logic             colon_q, colon_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             wrap_q, wrap_d;
   logic             term_cnt;
   logic             lead_blank;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

   always_comb begin
      digit_d = digit_q;
      colon_d = colon_q;
      if (bus.load) begin
         digit_d[3] = bus.d3;
         digit_d[2] = bus.d2;
         digit_d[1] = bus.d1;
         digit_d[0] = bus.d0;
         colon_d    = bus.colon;
      end

      term_cnt = (presc_q == DIV_W'(SCAN_DIV - 1));
      presc_d  = term_cnt ? '0 : presc_q + DIV_W'(1);
      idx_d    = term_cnt ? idx_q + 2'd1 : idx_q;
      wrap_d   = term_cnt && (idx_q == 2'd3);

      // Outputs are computed from the pre-edge index and digits, giving one cycle of latency.
      seg_d = decode(digit_q[idx_q]);
      dp_d  = !((idx_q == 2'd2) && colon_q);
      an_d  = ~(4'b0001 << idx_q);

`ifdef LEADING_ZERO_BLANK_EN
      lead_blank = ((idx_q == 2'd3) && (digit_q[3] == 4'd0)) ||
                   ((idx_q == 2'd2) && (digit_q[3] == 4'd0) && (digit_q[2] == 4'd0));
`else
      lead_blank = 1'b0;
`endif
      if (lead_blank) begin
         an_d  = 4'hF;
         seg_d = 7'h7F;
      end

      if (bus.blank) begin
         an_d = 4'hF;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            digit_q[i] <= 4'd0;
         end
         colon_q <= 1'b0;
         presc_q <= '0;
         idx_q   <= 2'd0;
         an_q    <= 4'hF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         wrap_q  <= 1'b0;
      end else begin
         digit_q <= digit_d;
         colon_q <= colon_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.an        = an_q;
   assign bus.seg       = seg_q;
   assign bus.dp        = dp_q;
   assign bus.scan_wrap = wrap_q;

endmodule
